// File: rtl/fetch_buffer.sv
// fetch_buffer: PC generation plus a DEPTH-entry {pc, instr} FIFO feeding decode
//   clk/rst        : clock, synchronous active-high reset
//   fetch_en       : allow fetching (0 holds the PC; the FIFO keeps draining)
//   imem_addr      : byte address to the instruction memory (the current fetch PC)
//   imem_rdata     : combinational instruction word for imem_addr
//   redirect_valid : flush the FIFO and load redirect_pc (word aligned)
//   redirect_pc    : redirect target
//   out_valid/out_ready : handshake to decode
//   out_instr/out_pc    : FIFO head, zero when empty
module fetch_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] fetch_pc;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic pop, push;
  assign imem_addr = fetch_pc;
  assign out_valid = count != '0;
  assign out_pc = out_valid ? mem[rd_ptr][63:32] : '0;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : '0;
  assign pop = out_valid & out_ready;
  // a full FIFO can still accept a fetch when the head leaves in the same cycle
  assign push = ~rst & fetch_en & ~redirect_valid & ((count != FULL) | pop);
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {fetch_pc, imem_rdata};
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'd3;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) fetch_pc <= fetch_pc + 32'd4;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= (push && !pop) ? count + (AW+1)'(1) : (pop && !push) ? count - (AW+1)'(1) : count;
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: table-driven check of fetch_buffer plus a PC wrap sequence
module tb_fetch_buffer;
  logic clk = 0, rst = 1, fetch_en = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic out_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc;
  logic w_valid;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a == 32'h0 ? 32'hFFC4A303 : a == 32'h4 ? 32'h0064A423 :
           a == 32'h8 ? 32'h0062E233 : a ^ 32'hDEAD_0000;
  endfunction
  assign imem_rdata = imem(imem_addr);
  assign w_rdata = imem(w_addr);
  fetch_buffer #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc));
  fetch_buffer #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) wrap_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(w_valid),
    .out_ready(out_ready), .out_instr(w_instr), .out_pc(w_pc));
  typedef struct {
    logic rst, en, rdy, rv;
    logic [31:0] rpc;
    logic ev;
    logic [31:0] epc, ei, ea;
  } vec_t;
  vec_t v[19];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask
  initial begin
    v[0]  = '{1,1,1,0,0, 0,32'h0,32'h0,32'h0};
    v[1]  = '{1,1,1,0,0, 0,32'h0,32'h0,32'h0};
    v[2]  = '{0,1,1,0,0, 1,32'h0,32'hFFC4A303,32'h4};
    v[3]  = '{0,1,1,0,0, 1,32'h4,32'h0064A423,32'h8};
    v[4]  = '{0,1,1,0,0, 1,32'h8,32'h0062E233,32'hC};
    v[5]  = '{0,1,1,0,0, 1,32'hC,32'hDEAD000C,32'h10};
    v[6]  = '{0,1,0,0,0, 1,32'hC,32'hDEAD000C,32'h14};
    v[7]  = '{0,1,0,0,0, 1,32'hC,32'hDEAD000C,32'h14};
    v[8]  = '{0,1,0,0,0, 1,32'hC,32'hDEAD000C,32'h14};
    v[9]  = '{0,1,1,0,0, 1,32'h10,32'hDEAD0010,32'h18};
    v[10] = '{0,1,1,0,0, 1,32'h14,32'hDEAD0014,32'h1C};
    v[11] = '{0,1,1,1,32'h103, 0,32'h0,32'h0,32'h100};
    v[12] = '{0,1,1,0,0, 1,32'h100,32'hDEAD0100,32'h104};
    v[13] = '{0,0,1,0,0, 0,32'h0,32'h0,32'h104};
    v[14] = '{0,0,1,0,0, 0,32'h0,32'h0,32'h104};
    v[15] = '{0,1,0,0,0, 1,32'h104,32'hDEAD0104,32'h108};
    v[16] = '{0,1,0,0,0, 1,32'h104,32'hDEAD0104,32'h10C};
    v[17] = '{1,1,1,0,0, 0,32'h0,32'h0,32'h0};
    v[18] = '{0,1,1,0,0, 1,32'h0,32'hFFC4A303,32'h4};
    for (int i = 0; i < 19; i++) begin
      rst = v[i].rst; fetch_en = v[i].en; out_ready = v[i].rdy;
      redirect_valid = v[i].rv; redirect_pc = v[i].rpc;
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i), {31'b0, out_valid}, {31'b0, v[i].ev});
      chk($sformatf("v%0d pc", i), out_pc, v[i].epc);
      chk($sformatf("v%0d instr", i), out_instr, v[i].ei);
      chk($sformatf("v%0d addr", i), imem_addr, v[i].ea);
    end
    rst = 1; fetch_en = 1; out_ready = 1; redirect_valid = 0;
    @(posedge clk); #1;
    chk("wrap reset addr", w_addr, 32'hFFFF_FFF8);
    chk("wrap reset valid", {31'b0, w_valid}, 32'h0);
    rst = 0;
    @(posedge clk); #1;
    chk("wrap pc0", w_pc, 32'hFFFF_FFF8);
    chk("wrap instr0", w_instr, 32'h2152FFF8);
    @(posedge clk); #1;
    chk("wrap pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap instr1", w_instr, 32'h2152FFFC);
    chk("wrap addr", w_addr, 32'h0);
    @(posedge clk); #1;
    chk("wrap pc2", w_pc, 32'h0);
    chk("wrap instr2", w_instr, 32'hFFC4A303);
    chk("wrap addr2", w_addr, 32'h4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
